// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared FSM state encoding and default debounce length
// for the step input conditioner.
package input_cond_pkg;
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
endpackage

// File: rtl/step_input_conditioner_if.sv
// step_input_conditioner_if: key/switch inputs and conditioned outputs.
//   key_n, w_raw      raw asynchronous pushbutton (0 = pressed) and switch bit
//   step              one-cycle pulse per accepted press
//   w_out             switch bit captured at the step
//   key_level         debounced key state, 1 = pressed
//   press_count       accepted presses, wraps at 256
interface step_input_conditioner_if;
    logic       key_n;
    logic       w_raw;
    logic       step;
    logic       w_out;
    logic       key_level;
    logic [7:0] press_count;
    modport master (output key_n, w_raw, input step, w_out, key_level, press_count);
    modport slave  (input key_n, w_raw, output step, w_out, key_level, press_count);
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchroniser with a configurable reset value.
//   clock, reset_n    system clock, asynchronous active-low reset
//   d                 asynchronous input
//   q                 synchronised output
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/step_input_conditioner.sv
// step_input_conditioner: debounces a raw active-low key into a one-cycle step
// pulse and captures the synchronised switch bit on that step.
//   clock, reset_n    system clock, asynchronous active-low reset
//   bus               slave side: key_n/w_raw in; step/w_out/key_level/press_count out
module step_input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic                       clock,
    input  logic                       reset_n,
    step_input_conditioner_if.slave    bus
);
    logic             key_s, w_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire, at_end;
    logic             step_q, w_q;
    logic [7:0]       count_q;

    sync2 #(.RST_VAL(1'b1)) u_key_sync (.clock(clock), .reset_n(reset_n), .d(bus.key_n), .q(key_s));
    sync2 #(.RST_VAL(1'b0)) u_w_sync   (.clock(clock), .reset_n(reset_n), .d(bus.w_raw), .q(w_s));

    assign at_end = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (at_end) begin
                    state_d = HELD;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (key_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    state_d = HELD;
                end else if (at_end) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            w_q     <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= fire;
            if (fire) begin
                w_q     <= w_s;
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign bus.step        = step_q;
    assign bus.w_out       = w_q;
    assign bus.key_level   = state_q[1];
    assign bus.press_count = count_q;
endmodule

// File: tb/tb_step_input_conditioner.sv
// tb_step_input_conditioner: directed scenarios with hand-computed expectations
// for the step input conditioner at DEBOUNCE_CYCLES = 4.
module tb_step_input_conditioner;
    localparam int D = 4;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;
    int   step_cnt = 0;
    int   base;
    logic [7:0] exp_count = 8'd0;

    step_input_conditioner_if bus();

    step_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (bus.step === 1'b1) step_cnt++;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.key_n = 1'b1;
        bus.w_raw = 1'b0;
        tick(3);
        checks++; if (bus.step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", bus.step); end
        checks++; if (bus.w_out !== 1'b0) begin failures++; $display("FAIL reset_w_out got=%b exp=0", bus.w_out); end
        checks++; if (bus.key_level !== 1'b0) begin failures++; $display("FAIL reset_key_level got=%b exp=0", bus.key_level); end
        checks++; if (bus.press_count !== 8'd0) begin failures++; $display("FAIL reset_press_count got=%0d exp=0", bus.press_count); end
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_clean_press;
        base = step_cnt;
        bus.w_raw = 1'b1;
        tick(2);
        bus.key_n = 1'b0;
        tick(D + 2);
        checks++; if (bus.step !== 1'b0) begin failures++; $display("FAIL clean_early_step got=%b exp=0", bus.step); end
        tick(1);
        exp_count++;
        checks++; if (bus.step !== 1'b1) begin failures++; $display("FAIL clean_step got=%b exp=1", bus.step); end
        checks++; if (bus.w_out !== 1'b1) begin failures++; $display("FAIL clean_w_out got=%b exp=1", bus.w_out); end
        checks++; if (bus.press_count !== exp_count) begin failures++; $display("FAIL clean_press_count got=%0d exp=%0d", bus.press_count, exp_count); end
        checks++; if (bus.key_level !== 1'b1) begin failures++; $display("FAIL clean_key_level got=%b exp=1", bus.key_level); end
        tick(1);
        checks++; if (bus.step !== 1'b0) begin failures++; $display("FAIL clean_step_width got=%b exp=0", bus.step); end
        bus.key_n = 1'b1;
        tick(D + 2);
        checks++; if (bus.key_level !== 1'b1) begin failures++; $display("FAIL clean_release_early got=%b exp=1", bus.key_level); end
        tick(1);
        checks++; if (bus.key_level !== 1'b0) begin failures++; $display("FAIL clean_release got=%b exp=0", bus.key_level); end
        tick(2);
        checks++; if (step_cnt - base !== 1) begin failures++; $display("FAIL clean_step_total got=%0d exp=1", step_cnt - base); end
    endtask

    task automatic test_bounce;
        base = step_cnt;
        bus.key_n = 1'b0;
        tick(3);
        bus.key_n = 1'b1;
        tick(1);
        bus.key_n = 1'b0;
        tick(D + 2);
        checks++; if (step_cnt - base !== 0) begin failures++; $display("FAIL bounce_no_step got=%0d exp=0", step_cnt - base); end
        checks++; if (bus.step !== 1'b0) begin failures++; $display("FAIL bounce_early_step got=%b exp=0", bus.step); end
        tick(1);
        exp_count++;
        checks++; if (bus.step !== 1'b1) begin failures++; $display("FAIL bounce_step got=%b exp=1", bus.step); end
        checks++; if (bus.press_count !== exp_count) begin failures++; $display("FAIL bounce_press_count got=%0d exp=%0d", bus.press_count, exp_count); end
        bus.key_n = 1'b1;
        tick(D + 5);
        checks++; if (step_cnt - base !== 1) begin failures++; $display("FAIL bounce_step_total got=%0d exp=1", step_cnt - base); end
    endtask

    task automatic test_long_hold;
        base = step_cnt;
        bus.w_raw = 1'b0;
        bus.key_n = 1'b0;
        tick(D + 3);
        exp_count++;
        checks++; if (bus.step !== 1'b1) begin failures++; $display("FAIL long_step got=%b exp=1", bus.step); end
        tick(100);
        checks++; if (step_cnt - base !== 1) begin failures++; $display("FAIL long_step_total got=%0d exp=1", step_cnt - base); end
        checks++; if (bus.key_level !== 1'b1) begin failures++; $display("FAIL long_key_level got=%b exp=1", bus.key_level); end
        checks++; if (bus.w_out !== 1'b0) begin failures++; $display("FAIL long_w_out got=%b exp=0", bus.w_out); end
        bus.key_n = 1'b1;
        tick(1);
        bus.key_n = 1'b0;
        tick(1);
        bus.key_n = 1'b1;
        tick(D + 2);
        checks++; if (bus.key_level !== 1'b1) begin failures++; $display("FAIL long_release_early got=%b exp=1", bus.key_level); end
        tick(1);
        checks++; if (bus.key_level !== 1'b0) begin failures++; $display("FAIL long_release got=%b exp=0", bus.key_level); end
        tick(2);
        checks++; if (bus.press_count !== exp_count) begin failures++; $display("FAIL long_press_count got=%0d exp=%0d", bus.press_count, exp_count); end
    endtask

    task automatic test_data_capture;
        logic [2:0] pat;
        pat = 3'b101;
        for (int p = 0; p < 3; p++) begin
            bus.w_raw = pat[p];
            tick(2);
            bus.key_n = 1'b0;
            tick(D + 3);
            exp_count++;
            checks++; if (bus.step !== 1'b1) begin failures++; $display("FAIL capture_step[%0d] got=%b exp=1", p, bus.step); end
            checks++; if (bus.w_out !== pat[p]) begin failures++; $display("FAIL capture_w_out[%0d] got=%b exp=%b", p, bus.w_out, pat[p]); end
            bus.w_raw = ~pat[p];
            tick(4);
            checks++; if (bus.w_out !== pat[p]) begin failures++; $display("FAIL capture_hold[%0d] got=%b exp=%b", p, bus.w_out, pat[p]); end
            bus.key_n = 1'b1;
            tick(D + 4);
            checks++; if (bus.w_out !== pat[p]) begin failures++; $display("FAIL capture_idle_hold[%0d] got=%b exp=%b", p, bus.w_out, pat[p]); end
        end
        checks++; if (bus.press_count !== exp_count) begin failures++; $display("FAIL capture_press_count got=%0d exp=%0d", bus.press_count, exp_count); end
    endtask

    task automatic test_async_reset;
        bus.w_raw = 1'b1;
        bus.key_n = 1'b0;
        tick(4);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.step !== 1'b0) begin failures++; $display("FAIL areset_step got=%b exp=0", bus.step); end
        checks++; if (bus.w_out !== 1'b0) begin failures++; $display("FAIL areset_w_out got=%b exp=0", bus.w_out); end
        checks++; if (bus.key_level !== 1'b0) begin failures++; $display("FAIL areset_key_level got=%b exp=0", bus.key_level); end
        checks++; if (bus.press_count !== 8'd0) begin failures++; $display("FAIL areset_press_count got=%0d exp=0", bus.press_count); end
        tick(2);
        reset_n = 1'b1;
        base = step_cnt;
        tick(D + 2);
        checks++; if (step_cnt - base !== 0 || bus.step !== 1'b0) begin failures++; $display("FAIL areset_early_step got=%b exp=0", bus.step); end
        tick(1);
        checks++; if (bus.step !== 1'b1) begin failures++; $display("FAIL areset_redebounce_step got=%b exp=1", bus.step); end
        checks++; if (bus.press_count !== 8'd1) begin failures++; $display("FAIL areset_redebounce_count got=%0d exp=1", bus.press_count); end
        bus.key_n = 1'b1;
        tick(D + 5);
    endtask

    task automatic test_wrap;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        base = step_cnt;
        for (int i = 0; i < 256; i++) begin
            bus.key_n = 1'b0;
            tick(D + 4);
            bus.key_n = 1'b1;
            tick(D + 4);
            if (i == 254) begin
                checks++; if (bus.press_count !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", bus.press_count); end
            end
        end
        checks++; if (bus.press_count !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", bus.press_count); end
        checks++; if (step_cnt - base !== 256) begin failures++; $display("FAIL wrap_step_total got=%0d exp=256", step_cnt - base); end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_long_hold;
        test_data_capture;
        test_async_reset;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/step_input_conditioner.md
# step_input_conditioner

Upstream front-end for the board-level sequence detector. It turns a raw, bouncing, active-low pushbutton and a raw slide-switch data bit into a clean one-cycle `step` enable and a `w_out` bit captured at that step. The detector's state register then advances exactly once per physical press on the free-running board clock, instead of using the key directly as its clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz); legal range ≥ 2.
- `CNT_W`, 20: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clock`  in  1: free-running system clock; all state is posedge.
- `reset_n`  in  1: one clock; reset is asynchronous and active-low.
- `key_n`  in  1: raw pushbutton, asynchronous, 0 = pressed.
- `w_raw`  in  1: raw switch data bit, asynchronous.
- `step`  out  1: one-cycle pulse per accepted press.
- `w_out`  out  1: `w_raw` value (synchronised) captured on the edge that raises `step`; held until the next step.
- `key_level`  out  1: debounced key state, 1 = pressed.
- `press_count`  out  8: number of accepted presses, wraps 255 -> 0.

## Operation
- `key_n` and `w_raw` each pass through a 2-flop synchroniser. Reset values are `key_s` = 1 (released) and `w_s` = 0.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Reset state is IDLE.
- IDLE: when `key_s` = 0, go to PRESS_WAIT and clear the counter.
- PRESS_WAIT: if `key_s` = 1 (bounce), return to IDLE. Otherwise increment the counter. When the counter = DEBOUNCE_CYCLES-1 and `key_s` = 0, go to HELD.
- HELD: when `key_s` = 1, go to RELEASE_WAIT and clear the counter.
- RELEASE_WAIT: if `key_s` = 0, return to HELD. If the counter = DEBOUNCE_CYCLES-1 and `key_s` = 1, go to IDLE.
- PRESS_WAIT -> HELD transition: register `step` = 1 for exactly one cycle, load `w_out` <= `w_s`, and increment `press_count` (mod 256).
- `key_level` = 1 in HELD and RELEASE_WAIT, 0 otherwise.
- The counter is only meaningful in the two WAIT states. It cannot overflow, because it never exceeds DEBOUNCE_CYCLES-1.
- A press held indefinitely produces exactly one `step`. There is no auto-repeat.
- A bounce at any count restarts debouncing from zero. A bounce never produces a `step`.
- `reset_n` low at any point, including mid-count: all flops clear immediately. Outputs read `step`=0, `w_out`=0, `key_level`=0, `press_count`=0, and the FSM returns to IDLE. A key still pressed after reset release must be fully re-debounced before `step` fires.

## Timing
- t0 is the clock edge at which the first synchroniser flop captures `key_n` = 0.
- The FSM enters PRESS_WAIT at edge t0+2.
- With the key held stable, `step` is high in the cycle after edge t0+2+DEBOUNCE_CYCLES. Total latency is DEBOUNCE_CYCLES+2 edges.
- `w_out` and `press_count` update on the same edge that raises `step`. Downstream may sample all three together on the edge after.
- `w_raw` must be stable for 2 cycles before the capture edge to be reflected in `w_out`.
- Release debounce has the same latency. `key_level` falls DEBOUNCE_CYCLES+2 edges after the first released sample.
- Minimum press-to-press spacing is 2×(DEBOUNCE_CYCLES+2) cycles. Faster activity is filtered as bounce.

## Structure
- Shared package `input_cond_pkg`: FSM state localparams IDLE=2'b00, PRESS_WAIT=2'b01, HELD=2'b10, RELEASE_WAIT=2'b11, and the default DEBOUNCE_CYCLES.
- Sub-module `sync2`: a two-flop synchroniser with a parameterised reset value, instantiated for `key_n` (reset 1) and `w_raw` (reset 0).
- The top level holds the FSM, the counter, and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: assert `reset_n` = 0 mid-PRESS_WAIT -> all outputs 0 immediately (asynchronous), state IDLE.
- Clean press: hold `key_n` = 0 with `w_raw` = 1 -> exactly one `step` pulse 6 edges after t0, `w_out` = 1, `press_count` = 1, `key_level` = 1.
- Bounce: `key_n` low for 3 cycles, high for 1, then low and held -> no `step` before the restart; `step` 6 edges after the final falling sample; `press_count` = 1.
- Long hold and release: hold 100 cycles, release with a 2-cycle bounce -> exactly one `step`; `key_level` falls 6 edges after the last released sample.
- Data capture: toggle `w_raw` 1,0,1 across three separated presses -> `w_out` reads 1,0,1 at the respective steps and holds between them.
- Wrap: 256 accepted presses -> `press_count` returns to 0; `step` count = 256.
